// File: rtl/g3_chain_search.sv
// g3_chain_search
//   One G3 subset table plus a chain walker. A search starts at req_index and
//   follows next pointers one entry per cycle until the key matches, the chain
//   ends (NULL pointer or out-of-range index), or MAX_HOPS entries have been
//   visited. The result is presented combinationally in the cycle its entry is
//   read, then held in registers until the next result.
//
//   Entry layout: {next[IDX], ruleID[IDX], valid, key[KEY_W]}. NULL = all ones.
//   The table is never reset. It is filled through the write port; no preload
//   image is built in.
//
// Optional build macro: G3_HOP_COUNT_EN
//   adds rsp_hops (entries visited for the result) and stat_aborts (saturating
//   count of hop-limit aborts).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     search request handshake (ready only in IDLE)
//   req_index, req_key  chain start entry and key to look for
//   rsp_valid           one-cycle result pulse
//   rsp_match/ruleID    hit flag and ruleID of hit entry (0 on miss)
//   rsp_abort           miss caused by the hop limit
//   we, waddr, din      table write port, active in any state
module g3_chain_search #(
  parameter int INDEX_BIT_LEN = 11,
  parameter int KEY_W         = 64,
  parameter int TABLE_DEPTH   = 2048,
  parameter int MAX_HOPS      = 16,
  localparam int ENTRY_W      = 2*INDEX_BIT_LEN + 1 + KEY_W,
  localparam int HW           = $clog2(MAX_HOPS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [INDEX_BIT_LEN-1:0] req_index,
  input  logic [KEY_W-1:0]         req_key,
  output logic                     rsp_valid,
  output logic                     rsp_match,
  output logic [INDEX_BIT_LEN-1:0] rsp_ruleID,
  output logic                     rsp_abort,
`ifdef G3_HOP_COUNT_EN
  output logic [HW-1:0]            rsp_hops,
  output logic [15:0]              stat_aborts,
`endif
  input  logic                     we,
  input  logic [INDEX_BIT_LEN-1:0] waddr,
  input  logic [ENTRY_W-1:0]       din
);

  localparam logic [INDEX_BIT_LEN-1:0] NULL_IDX = '1;

  typedef enum logic {IDLE, WALK} state_t;

  state_t                     state, state_nx;
  logic [ENTRY_W-1:0]         mem [TABLE_DEPTH];
  logic [ENTRY_W-1:0]         rdata;
  logic                       rd_oob;
  logic                       rd_en;
  logic [INDEX_BIT_LEN-1:0]   raddr;
  logic                       raddr_oob;
  logic [KEY_W-1:0]           key_q;
  logic [HW-1:0]              hops_q, hops_nx;

  logic                       fire, hit, chain_end, abort_c;
  logic                       match_q, abort_q;
  logic [INDEX_BIT_LEN-1:0]   rule_q;

  logic [INDEX_BIT_LEN-1:0]   e_next, e_rule;
  logic                       e_valid;
  logic [KEY_W-1:0]           e_key;

  assign e_next  = rdata[ENTRY_W-1 -: INDEX_BIT_LEN];
  assign e_rule  = rdata[KEY_W+1 +: INDEX_BIT_LEN];
  assign e_valid = rdata[KEY_W];
  assign e_key   = rdata[KEY_W-1:0];

  assign raddr_oob = int'(raddr) >= TABLE_DEPTH;

  // Table: read-first, so a same-cycle write to the read address is seen only
  // by the following access. Writes ignore reset on purpose.
  always_ff @(posedge clk) begin
    if (we && int'(waddr) < TABLE_DEPTH)
      mem[waddr] <= din;
    if (rd_en) begin
      rdata  <= raddr_oob ? '0 : mem[raddr];
      rd_oob <= raddr_oob;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hops_q  <= '0;
      match_q <= 1'b0;
      rule_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state  <= state_nx;
      hops_q <= hops_nx;
      if (state == IDLE && req_valid)
        key_q <= req_key;
      if (fire) begin
        match_q <= hit;
        rule_q  <= hit ? e_rule : '0;
        abort_q <= abort_c;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    rd_en     = 1'b0;
    raddr     = req_index;
    hops_nx   = hops_q;
    fire      = 1'b0;
    abort_c   = 1'b0;
    // An out-of-range read yields an all-zero entry; rd_oob ends the chain
    // since its zero next field is not NULL.
    hit       = e_valid && (e_key == key_q) && !rd_oob;
    chain_end = (e_next == NULL_IDX) || rd_oob;
    case (state)
      IDLE: begin
        if (req_valid) begin
          rd_en    = 1'b1;
          hops_nx  = HW'(1);
          state_nx = WALK;
        end
      end
      WALK: begin
        if (hit || chain_end) begin
          fire     = 1'b1;
          state_nx = IDLE;
        end else if (hops_q == HW'(MAX_HOPS)) begin
          fire     = 1'b1;
          abort_c  = 1'b1;
          state_nx = IDLE;
        end else begin
          rd_en    = 1'b1;
          raddr    = e_next;
          hops_nx  = hops_q + HW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    // Reset abandons a walk silently.
    if (rst) begin
      state_nx = IDLE;
      rd_en    = 1'b0;
      fire     = 1'b0;
      abort_c  = 1'b0;
      hops_nx  = '0;
    end
  end

  assign req_ready  = (state == IDLE);
  assign rsp_valid  = fire;
  assign rsp_match  = fire ? hit : match_q;
  assign rsp_ruleID = fire ? (hit ? e_rule : '0) : rule_q;
  assign rsp_abort  = fire ? abort_c : abort_q;

`ifdef G3_HOP_COUNT_EN
  logic [HW-1:0] rsp_hops_q;
  logic [15:0]   aborts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_hops_q <= '0;
      aborts_q   <= '0;
    end else begin
      if (fire)
        rsp_hops_q <= hops_q;
      if (fire && abort_c && aborts_q != 16'hFFFF)
        aborts_q <= aborts_q + 16'd1;
    end
  end

  assign rsp_hops    = fire ? hops_q : rsp_hops_q;
  assign stat_aborts = aborts_q;
`endif

endmodule

// File: tb/tb_g3_chain_search.sv
module tb_g3_chain_search;
  localparam int IDX = 11;
  localparam int KW  = 64;
  localparam int EW  = 2*IDX + 1 + KW;
  localparam int MH  = 16;
  localparam int HW  = $clog2(MH + 1);
  localparam logic [IDX-1:0] NUL = '1;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [IDX-1:0] req_index;
  logic [KW-1:0]  req_key;
  logic           rsp_valid, rsp_match, rsp_abort;
  logic [IDX-1:0] rsp_ruleID;
  logic           we;
  logic [IDX-1:0] waddr;
  logic [EW-1:0]  din;
`ifdef G3_HOP_COUNT_EN
  logic [HW-1:0]  rsp_hops;
  logic [15:0]    stat_aborts;
`endif

  g3_chain_search #(.INDEX_BIT_LEN(IDX), .KEY_W(KW), .TABLE_DEPTH(2048), .MAX_HOPS(MH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_match(rsp_match), .rsp_ruleID(rsp_ruleID), .rsp_abort(rsp_abort),
`ifdef G3_HOP_COUNT_EN
    .rsp_hops(rsp_hops), .stat_aborts(stat_aborts),
`endif
    .we(we), .waddr(waddr), .din(din)
  );

  always #5 clk = ~clk;

  typedef struct { bit m; int rule; bit ab; int lat; int hops; } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  logic [KW-1:0] ka, kb, kc, kz;

  function automatic logic [EW-1:0] mk(logic [IDX-1:0] nx, logic [IDX-1:0] r, logic v, logic [KW-1:0] k);
    return {nx, r, v, k};
  endfunction

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic wr(input int a, input logic [EW-1:0] e);
    @(negedge clk);
    we = 1'b1; waddr = IDX'(a); din = e;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Returns at the falling edge of the first cycle after acceptance.
  task automatic issue(input int idx, input logic [KW-1:0] key);
    bit acc = 0;
    @(negedge clk);
    req_valid = 1'b1; req_index = IDX'(idx); req_key = key;
    for (int n = 0; n < 40 && !acc; n++) begin
      if (req_ready) acc = 1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL issue_timeout: req_ready never high for idx %0d", idx);
    end
  endtask

  // Latency in cycles after acceptance; 0 if no response within the bound.
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (rsp_valid) begin lat = n; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({req_ready, rsp_valid, rsp_match, rsp_ruleID, rsp_abort} !== {1'b1, 1'b0, 1'b0, IDX'(0), 1'b0}) begin
      bad++;
      $display("FAIL reset: ready=%0b valid=%0b match=%0b rule=%0h abort=%0b, want 1 0 0 0 0",
               req_ready, rsp_valid, rsp_match, rsp_ruleID, rsp_abort);
    end
`ifdef G3_HOP_COUNT_EN
    total++;
    if (rsp_hops !== '0 || stat_aborts !== '0) begin
      bad++; $display("FAIL reset_counters: hops=%0d aborts=%0d, want 0 0", rsp_hops, stat_aborts);
    end
`endif
  endtask

  task automatic test_single_hit();
    int lat; exp_t e;
    wr(5, mk(NUL, 7, 1, ka));
    sb.push_back('{1, 7, 0, 1, 1});
    issue(5, ka); wait_rsp(lat); e = sb.pop_front();
    total++;
    if ({rsp_match, rsp_ruleID, rsp_abort} !== {e.m, IDX'(e.rule), e.ab} || lat != e.lat) begin
      bad++; $display("FAIL single_hit: m=%0b r=%0h a=%0b lat=%0d, want %0b %0h %0b %0d",
                      rsp_match, rsp_ruleID, rsp_abort, lat, e.m, e.rule, e.ab, e.lat);
    end
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL ready_in_rsp: got %0b want 0", req_ready); end
  endtask

  task automatic test_chain_hit();
    int lat; exp_t e;
    wr(3, mk(9, 1, 1, ka)); wr(9, mk(12, 2, 1, kb)); wr(12, mk(NUL, 'h2A, 1, kc));
    sb.push_back('{1, 'h2A, 0, 3, 3});
    issue(3, kc); wait_rsp(lat); e = sb.pop_front();
    total++;
    if ({rsp_match, rsp_ruleID, rsp_abort} !== {e.m, IDX'(e.rule), e.ab} || lat != e.lat) begin
      bad++; $display("FAIL chain_hit: m=%0b r=%0h a=%0b lat=%0d, want %0b %0h %0b %0d",
                      rsp_match, rsp_ruleID, rsp_abort, lat, e.m, e.rule, e.ab, e.lat);
    end
`ifdef G3_HOP_COUNT_EN
    total++;
    if (rsp_hops !== HW'(e.hops)) begin bad++; $display("FAIL chain_hops: got %0d want %0d", rsp_hops, e.hops); end
`endif
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_match, rsp_ruleID} !== {1'b0, 1'b1, IDX'('h2A)}) begin
      bad++; $display("FAIL chain_hold: v=%0b m=%0b r=%0h, want 0 1 2a", rsp_valid, rsp_match, rsp_ruleID);
    end
  endtask

  task automatic test_chain_null();
    int lat; exp_t e;
    wr(3, mk(9, 1, 1, ka)); wr(9, mk(NUL, 2, 1, kb));
    sb.push_back('{0, 0, 0, 2, 2});
    issue(3, kz); wait_rsp(lat); e = sb.pop_front();
    total++;
    if ({rsp_match, rsp_ruleID, rsp_abort} !== {e.m, IDX'(e.rule), e.ab} || lat != e.lat) begin
      bad++; $display("FAIL chain_null: m=%0b r=%0h a=%0b lat=%0d, want %0b %0h %0b %0d",
                      rsp_match, rsp_ruleID, rsp_abort, lat, e.m, e.rule, e.ab, e.lat);
    end
    // Valid bit clear: matching key must still miss.
    wr(40, mk(NUL, 9, 0, ka));
    sb.push_back('{0, 0, 0, 1, 1});
    issue(40, ka); wait_rsp(lat); e = sb.pop_front();
    total++;
    if ({rsp_match, rsp_ruleID, rsp_abort} !== {e.m, IDX'(e.rule), e.ab} || lat != e.lat) begin
      bad++; $display("FAIL invalid_entry: m=%0b r=%0h a=%0b lat=%0d, want %0b %0h %0b %0d",
                      rsp_match, rsp_ruleID, rsp_abort, lat, e.m, e.rule, e.ab, e.lat);
    end
  endtask

  task automatic test_cycle_abort();
    int lat; exp_t e;
    wr(4, mk(6, 1, 1, ka)); wr(6, mk(4, 2, 1, kb));
    sb.push_back('{0, 0, 1, MH, MH});
    issue(4, kz); wait_rsp(lat); e = sb.pop_front();
    total++;
    if ({rsp_match, rsp_ruleID, rsp_abort} !== {e.m, IDX'(e.rule), e.ab} || lat != e.lat) begin
      bad++; $display("FAIL cycle_abort: m=%0b r=%0h a=%0b lat=%0d, want %0b %0h %0b %0d",
                      rsp_match, rsp_ruleID, rsp_abort, lat, e.m, e.rule, e.ab, e.lat);
    end
`ifdef G3_HOP_COUNT_EN
    total++;
    if (rsp_hops !== HW'(e.hops)) begin bad++; $display("FAIL abort_hops: got %0d want %0d", rsp_hops, e.hops); end
    @(negedge clk);
    total++;
    if (stat_aborts !== 16'd1) begin bad++; $display("FAIL stat_aborts: got %0d want 1", stat_aborts); end
`endif
  endtask

  task automatic test_write_in_accept();
    int lat; exp_t e;
    // New entry 9 written while entry 3 is being read: hop 2 sees it.
    wr(3, mk(9, 1, 1, ka)); wr(9, mk(NUL, 4, 1, kb));
    sb.push_back('{1, 'h11, 0, 2, 2});
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL wa_ready: got %0b want 1", req_ready); end
    req_valid = 1'b1; req_index = IDX'(3); req_key = kc;
    we = 1'b1; waddr = IDX'(9); din = mk(NUL, 'h11, 1, kc);
    @(negedge clk);
    req_valid = 1'b0; we = 1'b0;
    wait_rsp(lat); e = sb.pop_front();
    total++;
    if ({rsp_match, rsp_ruleID, rsp_abort} !== {e.m, IDX'(e.rule), e.ab} || lat != e.lat) begin
      bad++; $display("FAIL write_next: m=%0b r=%0h a=%0b lat=%0d, want %0b %0h %0b %0d",
                      rsp_match, rsp_ruleID, rsp_abort, lat, e.m, e.rule, e.ab, e.lat);
    end
    // Entry 3 rewritten in the same cycle it is read: old contents win.
    wr(3, mk(NUL, 5, 1, kz));
    sb.push_back('{1, 5, 0, 1, 1});
    @(negedge clk);
    req_valid = 1'b1; req_index = IDX'(3); req_key = kz;
    we = 1'b1; waddr = IDX'(3); din = mk(NUL, 6, 1, kz);
    @(negedge clk);
    req_valid = 1'b0; we = 1'b0;
    wait_rsp(lat); e = sb.pop_front();
    total++;
    if ({rsp_match, rsp_ruleID, rsp_abort} !== {e.m, IDX'(e.rule), e.ab} || lat != e.lat) begin
      bad++; $display("FAIL read_first: m=%0b r=%0h a=%0b lat=%0d, want %0b %0h %0b %0d",
                      rsp_match, rsp_ruleID, rsp_abort, lat, e.m, e.rule, e.ab, e.lat);
    end
    sb.push_back('{1, 6, 0, 1, 1});
    issue(3, kz); wait_rsp(lat); e = sb.pop_front();
    total++;
    if ({rsp_match, rsp_ruleID} !== {e.m, IDX'(e.rule)} || lat != e.lat) begin
      bad++; $display("FAIL write_landed: m=%0b r=%0h lat=%0d, want %0b %0h %0d",
                      rsp_match, rsp_ruleID, lat, e.m, e.rule, e.lat);
    end
  endtask

  task automatic test_reset_walk();
    int lat; int seen = 0; exp_t e;
    for (int i = 0; i < 4; i++) wr(30 + i, mk(IDX'(31 + i), IDX'(i), 1, ka));
    wr(34, mk(NUL, 'h33, 1, kb));
    issue(30, kb);             // now in cycle 1 (hop 1)
    if (rsp_valid) seen++;
    @(negedge clk);            // cycle 2 (hop 2)
    rst = 1'b1;
    #1 if (rsp_valid) seen++;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_walk_ready: got %0b want 1", req_ready); end
    for (int n = 0; n < 6; n++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL rst_walk_silent: rsp pulses=%0d want 0", seen); end
    sb.push_back('{1, 'h33, 0, 1, 1});
    issue(34, kb); wait_rsp(lat); e = sb.pop_front();
    total++;
    if ({rsp_match, rsp_ruleID, rsp_abort} !== {e.m, IDX'(e.rule), e.ab} || lat != e.lat) begin
      bad++; $display("FAIL rst_walk_next: m=%0b r=%0h a=%0b lat=%0d, want %0b %0h %0b %0d",
                      rsp_match, rsp_ruleID, rsp_abort, lat, e.m, e.rule, e.ab, e.lat);
    end
  endtask

  // Source holds req_valid high; one-hop hits come back every other cycle.
  task automatic test_back_to_back();
    int nrsp = 0; exp_t e;
    wr(5, mk(NUL, 7, 1, ka));
    for (int i = 0; i < 4; i++) sb.push_back('{1, 7, 0, 1, 1});
    @(negedge clk);
    req_valid = 1'b1; req_index = IDX'(5); req_key = ka;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 8) req_valid = 1'b0;
      if (rsp_valid) begin
        nrsp++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          total++;
          if ({rsp_match, rsp_ruleID, req_ready} !== {e.m, IDX'(e.rule), 1'b0} || n % 2 != 1) begin
            bad++; $display("FAIL b2b_rsp: cyc=%0d m=%0b r=%0h ready=%0b, want odd %0b %0h 0",
                            n, rsp_match, rsp_ruleID, req_ready, e.m, e.rule);
          end
        end
      end
    end
    total++;
    if (nrsp != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", nrsp); end
    sb.delete();
  endtask

  initial begin
    ka = {$urandom, $urandom}; kb = ka ^ 64'h1; kc = ka ^ 64'h8000_0000_0000_0000; kz = ~ka;
    rst = 1'b1; req_valid = 1'b0; req_index = '0; req_key = '0;
    we = 1'b0; waddr = '0; din = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_hit();
    test_chain_hit();
    test_chain_null();
    test_cycle_abort();
    test_write_in_accept();
    test_reset_walk();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
